// File: rtl/dff_bank_arbiter.sv
//------------------------------------------------------------------------------
// Module  : dff_bank_arbiter
// Purpose : Round-robin write sequencer for a shared DATA_W-bit flip-flop
//           register, with a HOLD_CYC quiet window after every write.
//           Optional macro ARB_STATS_EN adds saturating per-requester counters.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dff_bank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [2:0]                stat_sel_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic                      reg_we_o,
  output logic [DATA_W-1:0]         reg_d_o,
  output logic                      busy_o,
  output logic [2:0]                owner_o,
  output logic                      owner_vld_o,
  output logic [7:0]                stat_cnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [3:0]          hold_q, hold_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   regd_q, regd_d;
  logic [2:0]          owner_q, owner_d;
  logic                vld_q, vld_d;

  int                  best_off;
  int                  off;
  logic [NUM_REQ-1:0]  win_oh;
  logic [PTR_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                grant;

  // Winner is the requester at the smallest rotational distance from ptr_q.
  always_comb begin
    best_off = NUM_REQ;
    off      = 0;
    win_oh   = '0;
    win_idx  = '0;
    win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      off = j - int'(ptr_q);
      if (off < 0) off = off + NUM_REQ;
      if (req_i[j] && (off < best_off)) begin
        best_off = off;
        win_oh   = '0;
        win_oh[j] = 1'b1;
        win_idx  = PTR_W'(j);
        win_data = req_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign grant = (state_q == S_IDLE) && ena_i && (|req_i);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = '0;
    we_d    = 1'b0;
    regd_d  = regd_q;
    owner_d = owner_q;
    vld_d   = vld_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_WRITE;
          gnt_d   = win_oh;
          we_d    = 1'b1;
          regd_d  = win_data;
          owner_d = 3'(win_idx);
          vld_d   = 1'b1;
          ptr_d   = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_WRITE: begin
        if (HOLD_CYC == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
          hold_d  = 4'(HOLD_CYC);
        end
      end
      S_HOLD: begin
        if (hold_q <= 4'd1) begin
          state_d = S_IDLE;
          hold_d  = 4'd0;
        end else begin
          hold_d  = hold_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      hold_q  <= 4'd0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      regd_q  <= '0;
      owner_q <= 3'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      regd_q  <= regd_d;
      owner_q <= owner_d;
      vld_q   <= vld_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign reg_we_o    = we_q;
  assign reg_d_o     = regd_q;
  assign busy_o      = (state_q != S_IDLE);
  assign owner_o     = owner_q;
  assign owner_vld_o = vld_q;

`ifdef ARB_STATS_EN
  logic [7:0] cnt_q [NUM_REQ];
  logic [7:0] stat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_REQ; j++) cnt_q[j] <= 8'd0;
    end else if (grant) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (win_oh[j] && (cnt_q[j] != 8'hFF)) cnt_q[j] <= cnt_q[j] + 8'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = 8'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (stat_sel_i == 3'(j)) stat_cnt = cnt_q[j];
    end
  end

  assign stat_cnt_o = stat_cnt;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel_i;
  assign stat_cnt_o      = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_dff_bank_arbiter
// Purpose : Self-checking bench for dff_bank_arbiter against a cycle-level
//           behavioural model of the round-robin/hold rules.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dff_bank_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int HOLD = 2;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [2:0]    stat_sel;
  logic [NR-1:0] gnt;
  logic          reg_we;
  logic [DW-1:0] reg_d;
  logic          busy;
  logic [2:0]    owner;
  logic          owner_vld;
  logic [7:0]    stat_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_ptr;
  int          m_left;
  int          m_owner;
  logic [NR-1:0] m_gnt;
  logic [DW-1:0] m_d;
  logic        m_vld;
  int          m_cnt [NR];

  dff_bank_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_i      (ena),
    .req_i      (req),
    .req_data_i (req_data),
    .stat_sel_i (stat_sel),
    .gnt_o      (gnt),
    .reg_we_o   (reg_we),
    .reg_d_o    (reg_d),
    .busy_o     (busy),
    .owner_o    (owner),
    .owner_vld_o(owner_vld),
    .stat_cnt_o (stat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [17:0] obs;
  assign obs = {gnt, reg_we, reg_d, busy, owner, owner_vld};

  function automatic logic [17:0] exp_vec();
    return {m_gnt, |m_gnt, m_d, (m_left > 0), 3'(m_owner), m_vld};
  endfunction

  function automatic logic [7:0] exp_stat(input logic [2:0] sel);
`ifdef ARB_STATS_EN
    if (int'(sel) < NR) return 8'((m_cnt[sel] > 255) ? 255 : m_cnt[sel]);
    return 8'd0;
`else
    return (sel == 3'd7) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_left = 0; m_owner = 0; m_gnt = '0; m_d = '0; m_vld = 1'b0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
  endtask

  // One clock: model applies the arbitration rules to the inputs seen at the edge.
  task automatic step();
    int w;
    @(posedge clk);
    if (rst_n) begin
      if (m_left == 0 && ena && (|req)) begin
        w = -1;
        for (int k = 0; k < NR; k++) begin
          if (w < 0 && req[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        end
        m_gnt   = NR'(1 << w);
        m_d     = req_data[w*DW +: DW];
        m_owner = w;
        m_vld   = 1'b1;
        m_ptr   = (w + 1) % NR;
        m_left  = 1 + HOLD;
        m_cnt[w]++;
      end else begin
        m_gnt = '0;
        if (m_left > 0) m_left--;
      end
    end
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_left != 0; i++) step();
  endtask

  task automatic test_reset();
    #2;
    req = 4'hF; ena = 1'b1; rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (obs !== 18'd0) begin n_err++; $display("FAIL reset_async got=%h exp=%h", obs, 18'd0); end
    @(posedge clk); #1;
    n_chk++;
    if (obs !== 18'd0) begin n_err++; $display("FAIL reset_held got=%h exp=%h", obs, 18'd0); end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (gnt !== 4'b0001 || reg_we !== 1'b1) begin
      n_err++; $display("FAIL reset_first_grant got gnt=%b we=%b exp gnt=0001 we=1", gnt, reg_we);
    end
  endtask

  task automatic test_single();
    req = '0;
    wait_idle();
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    step();
    req = '0;
    n_chk++;
    if (gnt !== 4'b0100 || reg_we !== 1'b1 || reg_d !== 8'hA5 || owner !== 3'd2 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant got gnt=%b we=%b d=%h own=%0d busy=%b exp 0100 1 a5 2 1",
               gnt, reg_we, reg_d, owner, busy);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (busy !== (k < 2) || gnt !== 4'b0000 || reg_d !== 8'hA5) begin
        n_err++;
        $display("FAIL single_hold k=%0d got busy=%b gnt=%b d=%h exp busy=%b gnt=0000 d=a5",
                 k, busy, gnt, reg_d, (k < 2));
      end
    end
  endtask

  task automatic test_fairness();
    int order [8];
    int cyc   [8];
    int n;
    n = 0;
    rst_n = 1'b0; model_reset(); #2; rst_n = 1'b1;
    ena = 1'b1; req = 4'hF; req_data = {$urandom};
    for (int c = 1; c <= 17; c++) begin
      step();
      n_chk++;
      if ($countones(gnt) > 1 || obs !== exp_vec()) begin
        n_err++; $display("FAIL fair_cycle c=%0d got=%h exp=%h", c, obs, exp_vec());
      end
      for (int i = 0; i < NR; i++) begin
        if (gnt[i] && n < 8) begin order[n] = i; cyc[n] = c; n++; end
      end
    end
    n_chk++;
    if (n != 5) begin n_err++; $display("FAIL fair_count got=%0d exp=5", n); end
    for (int i = 0; i < 5 && i < n; i++) begin
      n_chk++;
      if (order[i] != (i % NR) || (i > 0 && cyc[i] - cyc[i-1] != 2 + HOLD)) begin
        n_err++;
        $display("FAIL fair_order i=%0d got idx=%0d gap=%0d exp idx=%0d gap=%0d",
                 i, order[i], (i > 0) ? cyc[i] - cyc[i-1] : 0, i % NR, 2 + HOLD);
      end
    end
  endtask

  task automatic test_wrap();
    req = '0;
    wait_idle();
    req_data = {$urandom};
    req = 4'b0100;
    step();
    req = '0;
    wait_idle();
    req = 4'b0010;
    step();
    req = '0;
    n_chk++;
    if (gnt !== 4'b0010 || obs !== exp_vec()) begin
      n_err++; $display("FAIL wrap_skip got gnt=%b vec=%h exp gnt=0010 vec=%h", gnt, obs, exp_vec());
    end
    wait_idle();
    req = 4'b1000;
    step();
    req = '0;
    n_chk++;
    if (gnt !== 4'b1000 || owner !== 3'd3) begin
      n_err++; $display("FAIL wrap_next got gnt=%b own=%0d exp gnt=1000 own=3", gnt, owner);
    end
  endtask

  task automatic test_ena_reset();
    req = '0;
    wait_idle();
    ena = 1'b0; req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      n_chk++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_err++; $display("FAIL ena_block k=%0d got gnt=%b busy=%b exp 0000 0", k, gnt, busy);
      end
    end
    ena = 1'b1;
    step();
    req = '0;
    n_chk++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL ena_resume got gnt=%b exp=0001", gnt); end
    step();
    step();
    n_chk++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy got=%b exp=1", busy); end
    rst_n = 1'b0; model_reset(); #1;
    n_chk++;
    if (busy !== 1'b0 || owner_vld !== 1'b0 || reg_d !== 8'h00) begin
      n_err++; $display("FAIL reset_mid_hold got busy=%b vld=%b d=%h exp 0 0 00", busy, owner_vld, reg_d);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      ena      = ($urandom_range(0, 7) != 0);
      req      = NR'($urandom);
      req_data = {$urandom};
      stat_sel = 3'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
      end
      step();
      n_chk++;
      if (obs !== exp_vec() || stat_cnt !== exp_stat(stat_sel) || $countones(gnt) > 1) begin
        n_err++;
        $display("FAIL random c=%0d got=%h stat=%0d exp=%h stat=%0d",
                 c, obs, stat_cnt, exp_vec(), exp_stat(stat_sel));
      end
    end
  endtask

  task automatic test_stats();
    int grants;
    logic [7:0] exp1;
    grants = 0;
    rst_n = 1'b0; model_reset(); #2; rst_n = 1'b1;
    ena = 1'b1; req = 4'b0010; req_data = {$urandom}; stat_sel = 3'd1;
    for (int c = 0; c < 1200 && grants < 300; c++) begin
      step();
      if (gnt[1]) grants++;
    end
    req = '0;
    n_chk++;
    if (grants != 300) begin n_err++; $display("FAIL stats_grants got=%0d exp=300", grants); end
`ifdef ARB_STATS_EN
    exp1 = 8'd255;
`else
    exp1 = 8'd0;
`endif
    stat_sel = 3'd1; #1;
    n_chk++;
    if (stat_cnt !== exp1) begin n_err++; $display("FAIL stats_sel1 got=%0d exp=%0d", stat_cnt, exp1); end
    stat_sel = 3'd5; #1;
    n_chk++;
    if (stat_cnt !== 8'd0) begin n_err++; $display("FAIL stats_sel5 got=%0d exp=0", stat_cnt); end
    stat_sel = 3'd0; #1;
    n_chk++;
    if (stat_cnt !== exp_stat(3'd0)) begin
      n_err++; $display("FAIL stats_sel0 got=%0d exp=%0d", stat_cnt, exp_stat(3'd0));
    end
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; req = '0; req_data = '0; stat_sel = 3'd0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_ena_reset();
    test_random();
    test_stats();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
